// File: rtl/ce_period_monitor_if.sv
// rtl/ce_period_monitor_if.sv - observed ce input and monitor status outputs
interface ce_period_monitor_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 sysce;
  logic                 ce_in;
  logic [CNT_WIDTH-1:0] period_out;
  logic                 period_valid;
  logic                 locked;
  logic                 ce_regen;
  logic                 missing_pulse;
  logic                 extra_pulse;
  logic [7:0]           err_count;

  modport master (
    output sysce, ce_in,
    input  period_out, period_valid, locked, ce_regen,
           missing_pulse, extra_pulse, err_count
  );

  modport slave (
    input  sysce, ce_in,
    output period_out, period_valid, locked, ce_regen,
           missing_pulse, extra_pulse, err_count
  );
endinterface

// File: rtl/ce_period_monitor.sv
// rtl/ce_period_monitor.sv - measures a ce pulse train, locks onto it and flywheels a regenerated ce
// Optional saturating error counter: CE_PERIOD_MONITOR_STATS_EN.
module ce_period_monitor #(
  parameter int CNT_WIDTH  = 16,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 2
) (
  input  logic               sysclk,
  input  logic               sysclr_n,
  ce_period_monitor_if.slave bus
);
  localparam int MCW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int XCW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;
  localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_ALL1    = '1;
  localparam logic [MCW-1:0]       LOCK_LAST = MCW'(LOCK_COUNT - 1);
  localparam logic [XCW-1:0]       MISS_LAST = XCW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TRACK, S_LOCKED} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_icnt;
  logic [CNT_WIDTH-1:0] r_phase;
  logic [CNT_WIDTH-1:0] r_period;
  logic [MCW-1:0]       r_mcnt;
  logic [XCW-1:0]       r_miss;
  logic                 r_valid;
  logic                 r_locked;
  logic                 r_missing;
  logic                 r_extra;

  logic w_pulse;
  logic w_in_locked;
  logic w_phase_hit;
  logic w_timeout;
  logic w_miss_ev;
  logic w_extra_ev;

  assign w_pulse     = bus.sysce & bus.ce_in;
  assign w_in_locked = (r_state == S_LOCKED);
  assign w_phase_hit = (r_phase == r_period);
  // A pulse in the same cycle as the saturation point keeps the measurement alive.
  assign w_timeout   = bus.sysce & ~w_pulse & (r_icnt == C_ALL1) & (r_state != S_IDLE);
  assign w_miss_ev   = bus.sysce & ~w_timeout & w_in_locked & w_phase_hit & ~w_pulse;
  assign w_extra_ev  = w_pulse & w_in_locked & ~w_phase_hit;

  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      r_state   <= S_IDLE;
      r_icnt    <= '0;
      r_phase   <= '0;
      r_period  <= '0;
      r_mcnt    <= '0;
      r_miss    <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_missing <= 1'b0;
      r_extra   <= 1'b0;
    end else if (!bus.sysce) begin
      r_missing <= 1'b0;
      r_extra   <= 1'b0;
    end else begin
      r_missing <= 1'b0;
      r_extra   <= 1'b0;
      if (w_pulse)
        r_icnt <= C_ONE;
      else if (r_icnt != C_ALL1)
        r_icnt <= r_icnt + C_ONE;

      if (w_timeout) begin
        r_state  <= S_IDLE;
        r_valid  <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_pulse)
              r_state <= S_MEASURE;
          end
          S_MEASURE: begin
            if (w_pulse) begin
              r_period <= r_icnt;
              r_valid  <= 1'b1;
              r_mcnt   <= '0;
              r_state  <= S_TRACK;
            end
          end
          S_TRACK: begin
            if (w_pulse) begin
              if (r_icnt == r_period) begin
                if (r_mcnt == LOCK_LAST) begin
                  r_state  <= S_LOCKED;
                  r_locked <= 1'b1;
                  r_phase  <= C_ONE;
                  r_miss   <= '0;
                end else begin
                  r_mcnt <= r_mcnt + 1'b1;
                end
              end else begin
                r_period <= r_icnt;
                r_mcnt   <= '0;
              end
            end
          end
          S_LOCKED: begin
            r_phase <= w_phase_hit ? C_ONE : r_phase + C_ONE;
            if (w_phase_hit) begin
              if (w_pulse) begin
                r_miss <= '0;
              end else begin
                r_missing <= 1'b1;
                if (r_miss == MISS_LAST) begin
                  r_state  <= S_IDLE;
                  r_valid  <= 1'b0;
                  r_locked <= 1'b0;
                end else begin
                  r_miss <= r_miss + 1'b1;
                end
              end
            end else if (w_pulse) begin
              // Early pulse: drop back to tracking but keep the known period as the reference.
              r_extra  <= 1'b1;
              r_state  <= S_TRACK;
              r_mcnt   <= '0;
              r_locked <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CE_PERIOD_MONITOR_STATS_EN
  logic [7:0] r_err;
  logic       w_err_ev;

  assign w_err_ev = w_timeout | w_miss_ev | w_extra_ev;

  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n)
      r_err <= 8'h00;
    else if (w_err_ev && (r_err != 8'hFF))
      r_err <= r_err + 8'h01;
  end

  assign bus.err_count = r_err;
`else
  logic w_unused_ev;
  assign w_unused_ev   = w_miss_ev | w_extra_ev;
  assign bus.err_count = {7'h00, w_unused_ev & 1'b0};
`endif

  assign bus.period_out    = r_period;
  assign bus.period_valid  = r_valid;
  assign bus.locked        = r_locked;
  assign bus.missing_pulse = r_missing;
  assign bus.extra_pulse   = r_extra;
  assign bus.ce_regen      = w_in_locked ? (bus.sysce & w_phase_hit) : w_pulse;
endmodule

// File: tb/tb_ce_period_monitor.sv
// tb/tb_ce_period_monitor.sv - scoreboard bench for ce_period_monitor against a timestamp reference model
module tb_ce_period_monitor;
  localparam int CW   = 4;
  localparam int LC   = 4;
  localparam int ML   = 2;
  localparam int MAXV = (1 << CW) - 1;
  localparam int M_IDLE = 0, M_MEASURE = 1, M_TRACK = 2, M_LOCKED = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ce_period_monitor_if #(.CNT_WIDTH(CW)) bus ();

  ce_period_monitor #(.CNT_WIDTH(CW), .LOCK_COUNT(LC), .MISS_LIMIT(ML)) dut (
    .sysclk   (clk),
    .sysclr_n (rst_n),
    .bus      (bus.slave)
  );

  typedef struct {
    int       cyc;
    int       period;
    bit       valid;
    bit       locked;
    bit       regen;
    bit       miss;
    bit       extra;
    int       err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   cyc      = 0;

  // Reference model: intervals and phase derived from pulse timestamps in sysce ticks.
  int m_state, m_tick, m_last, m_lock_tick, m_period, m_mcnt, m_miss, m_err;
  bit m_valid, m_locked, m_smiss, m_sext;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, c, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_tick = 0; m_last = 0; m_lock_tick = 0; m_period = 0;
    m_mcnt = 0; m_miss = 0; m_err = 0; m_valid = 0; m_locked = 0; m_smiss = 0; m_sext = 0;
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input bit se, input bit ce);
    exp_t e;
    int   icnt;
    bit   p, hit, tmo;
    p   = se && ce;
    hit = (m_state == M_LOCKED) && (((m_tick - m_lock_tick) % m_period) == 0);
    e.cyc = cyc; e.period = m_period; e.valid = m_valid; e.locked = m_locked;
    e.miss = m_smiss; e.extra = m_sext;
    e.regen = (m_state == M_LOCKED) ? (se && hit) : p;
`ifdef CE_PERIOD_MONITOR_STATS_EN
    e.err = m_err;
`else
    e.err = 0;
`endif
    q.push_back(e);
    cyc++;
    m_smiss = 0; m_sext = 0;
    if (!se) return;
    icnt = m_tick - m_last;
    if (icnt > MAXV) icnt = MAXV;
    tmo = !p && (icnt == MAXV) && (m_state != M_IDLE);
    if (tmo) begin
      m_state = M_IDLE; m_valid = 0; m_locked = 0; bump_err();
    end else begin
      case (m_state)
        M_IDLE: if (p) m_state = M_MEASURE;
        M_MEASURE: if (p) begin
          m_period = icnt; m_valid = 1; m_mcnt = 0; m_state = M_TRACK;
        end
        M_TRACK: if (p) begin
          if (icnt == m_period) begin
            m_mcnt++;
            if (m_mcnt == LC) begin
              m_state = M_LOCKED; m_locked = 1; m_lock_tick = m_tick; m_miss = 0;
            end
          end else begin
            m_period = icnt; m_mcnt = 0;
          end
        end
        default: begin
          if (hit) begin
            if (p) m_miss = 0;
            else begin
              m_smiss = 1; bump_err(); m_miss++;
              if (m_miss == ML) begin m_state = M_IDLE; m_valid = 0; m_locked = 0; end
            end
          end else if (p) begin
            m_sext = 1; bump_err(); m_state = M_TRACK; m_mcnt = 0; m_locked = 0;
          end
        end
      endcase
    end
    if (p) m_last = m_tick;
    m_tick++;
  endtask

  task automatic drive(input bit se, input bit ce);
    @(negedge clk);
    bus.sysce = se;
    bus.ce_in = ce;
    model_step(se, ce);
    mon_en = 1'b1;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          chk("queue_empty", cyc, 1, 0);
        end else begin
          e = q.pop_front();
          chk("period_out", e.cyc, 32'(bus.period_out), e.period);
          chk("period_valid", e.cyc, 32'(bus.period_valid), 32'(e.valid));
          chk("locked", e.cyc, 32'(bus.locked), 32'(e.locked));
          chk("ce_regen", e.cyc, 32'(bus.ce_regen), 32'(e.regen));
          chk("missing_pulse", e.cyc, 32'(bus.missing_pulse), 32'(e.miss));
          chk("extra_pulse", e.cyc, 32'(bus.extra_pulse), 32'(e.extra));
          chk("err_count", e.cyc, 32'(bus.err_count), e.err);
        end
      end
    end
  end

  task automatic check_all_zero(input string nm);
    chk({nm, "_period"}, cyc, 32'(bus.period_out), 0);
    chk({nm, "_valid"}, cyc, 32'(bus.period_valid), 0);
    chk({nm, "_locked"}, cyc, 32'(bus.locked), 0);
    chk({nm, "_regen"}, cyc, 32'(bus.ce_regen), 0);
    chk({nm, "_missing"}, cyc, 32'(bus.missing_pulse), 0);
    chk({nm, "_extra"}, cyc, 32'(bus.extra_pulse), 0);
    chk({nm, "_err"}, cyc, 32'(bus.err_count), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ce, se;
    int t, p, n;
    bus.sysce = 1'b0;
    bus.ce_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Lock at period 4, one isolated miss, then two consecutive misses.
    for (int c = 0; c <= 46; c++) begin
      drive(1'b1, (c % 4 == 0) && c != 28 && c != 40 && c != 44);
      if (c == 4)  chk("a_valid_before", c, 32'(bus.period_valid), 0);
      if (c == 5)  chk("a_period", c, 32'(bus.period_out), 4);
      if (c == 5)  chk("a_valid", c, 32'(bus.period_valid), 1);
      if (c == 20) chk("a_locked_pre", c, 32'(bus.locked), 0);
      if (c == 21) chk("a_locked", c, 32'(bus.locked), 1);
      if (c == 24) chk("a_regen", c, 32'(bus.ce_regen), 1);
      if (c == 28) chk("a_regen_flywheel", c, 32'(bus.ce_regen), 1);
      if (c == 29) chk("a_missing", c, 32'(bus.missing_pulse), 1);
      if (c == 29) chk("a_locked_hold", c, 32'(bus.locked), 1);
      if (c == 30) chk("a_missing_clear", c, 32'(bus.missing_pulse), 0);
      if (c == 45) chk("a_unlock", c, 32'(bus.locked), 0);
      if (c == 45) chk("a_valid_drop", c, 32'(bus.period_valid), 0);
    end

    // Extra pulse at offset 30, relock on the restarted train, then flywheel out.
    for (int c = 0; c <= 56; c++) begin
      drive(1'b1, (c <= 28 && c % 4 == 0) || (c >= 30 && c <= 46 && (c - 30) % 4 == 0));
      if (c == 31) chk("b_extra", c, 32'(bus.extra_pulse), 1);
      if (c == 31) chk("b_unlock", c, 32'(bus.locked), 0);
      if (c == 31) chk("b_period_kept", c, 32'(bus.period_out), 4);
      if (c == 46) chk("b_relock_pre", c, 32'(bus.locked), 0);
      if (c == 47) chk("b_relock", c, 32'(bus.locked), 1);
      if (c == 55) chk("b_idle", c, 32'(bus.locked), 0);
    end

    // Period 3 switching to period 5 while tracking.
    for (int c = 0; c <= 46; c++) begin
      drive(1'b1, (c <= 9 && c % 3 == 0) || (c >= 14 && c <= 34 && (c - 14) % 5 == 0));
      if (c == 14) chk("c_period3", c, 32'(bus.period_out), 3);
      if (c == 15) chk("c_period5", c, 32'(bus.period_out), 5);
      if (c == 34) chk("c_locked_pre", c, 32'(bus.locked), 0);
      if (c == 35) chk("c_locked", c, 32'(bus.locked), 1);
    end

    // Period 2 with a 10-cycle sysce stall; ce_in is noise while stalled.
    t = 0;
    for (int c = 0; c <= 45; c++) begin
      se = !(c >= 7 && c <= 16);
      ce = se ? (t % 2 == 0 && t <= 24) : 1'($urandom_range(0, 1));
      drive(se, ce);
      if (se) t++;
      if (c == 10) chk("d_regen_stall", c, 32'(bus.ce_regen), 0);
      if (c == 16) chk("d_period_stall", c, 32'(bus.period_out), 2);
      if (c == 20) chk("d_locked_pre", c, 32'(bus.locked), 0);
      if (c == 21) chk("d_locked", c, 32'(bus.locked), 1);
    end

    // Timeout out of TRACK after saturation.
    for (int c = 0; c <= 22; c++) begin
      drive(1'b1, c == 0 || c == 4);
      if (c == 19) chk("e_valid_pre", c, 32'(bus.period_valid), 1);
      if (c == 20) chk("e_timeout", c, 32'(bus.period_valid), 0);
    end

    // Randomized segments of jittered, gapped and stalled trains.
    repeat (60) begin
      p = $urandom_range(1, 7);
      n = $urandom_range(2, 12);
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < p; ) begin
          if ($urandom_range(0, 9) == 0) begin
            drive(1'b0, 1'($urandom_range(0, 1)));
          end else begin
            ce = (j == p - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
            drive(1'b1, ce);
            j++;
          end
        end
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) drive(1'b1, 1'b0);
    end

    // Relock, then assert reset asynchronously mid-cycle.
    repeat (40) drive(1'b1, 1'b0);
    for (int c = 0; c <= 22; c++) begin
      drive(1'b1, c % 4 == 0);
      if (c == 21) chk("f_locked", c, 32'(bus.locked), 1);
    end
    @(posedge clk);
    mon_en = 1'b0;
    #2;
    bus.ce_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", cyc, 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
